// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-addressable data memory bank.
// Little-endian: byte lane = addr[1:0], half lane = addr[1].
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   function automatic logic lane_misaligned(input size_e sz, input logic [1:0] a);
      logic bad;
      case (sz)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = a[0];
         SZ_W:    bad = (a != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] a);
      logic [3:0] be;
      case (sz)
         SZ_B:    be = 4'b0001 << a;
         SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate the right-aligned store data into every lane; byte enables pick the target.
   function automatic logic [31:0] lane_merge(input size_e sz, input logic [31:0] wd);
      logic [31:0] w;
      case (sz)
         SZ_B:    w = {4{wd[7:0]}};
         SZ_H:    w = {2{wd[15:0]}};
         default: w = wd;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] lane_extract(input size_e sz, input logic [1:0] a,
                                                input logic uns, input logic [31:0] word);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      sh = word >> {a, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (sz)
         SZ_B:    r = uns ? {24'h0, sh[7:0]} : 32'(b);
         SZ_H:    r = uns ? {16'h0, sh[15:0]} : 32'(h);
         SZ_W:    r = word;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// Request/response bus between a load/store requester and dmem_bank.
interface dmem_bank_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store byte enables and lane data, load extract/extend,
// and alignment/size fault detection.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] rext,
   output logic        misalign
);

   size_e sz;

   assign sz       = size_e'(size);
   assign be       = lane_be(sz, addr_lo);
   assign wlane    = lane_merge(sz, wdata);
   assign rext     = lane_extract(sz, addr_lo, is_unsigned, rword);
   assign misalign = lane_misaligned(sz, addr_lo);

endmodule

// File: rtl/dmem_bank.sv
// Single-port data memory bank with configurable response latency, byte/half/word
// access, sign/zero extension on loads and fault reporting.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 0
) (
   input  logic       clk,
   input  logic       reset,
   dmem_bank_if.slave bus
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   state_e      state_p0, state_nx;
   logic [2:0]  cnt_p0, cnt_nx;
   logic        enter_resp;

   logic        we_p0, uns_p0;
   logic [1:0]  size_p0;
   logic [31:0] addr_p0, wdata_p0;

   logic        sel_live;
   logic        cur_we, cur_uns;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr, cur_wdata;

   logic [AW-1:0] idx;
   logic [31:0]   rword, wlane, rext;
   logic [3:0]    be;
   logic          misalign, range_err, err;

   logic [31:0] mem [DEPTH];

   logic        vld_p1, err_p1;
   logic [31:0] rdata_p1;

   assign bus.req_ready = (state_p0 == IDLE) && !reset;

   always_comb begin
      state_nx   = state_p0;
      cnt_nx     = cnt_p0;
      enter_resp = 1'b0;
      case (state_p0)
         IDLE: begin
            if (bus.req_valid) begin
               if (LATENCY == 0) begin
                  state_nx   = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_p0 == 3'd0) begin
               state_nx   = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nx = cnt_p0 - 3'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (reset) enter_resp = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_p0 <= IDLE;
         cnt_p0   <= 3'd0;
      end else begin
         state_p0 <= state_nx;
         cnt_p0   <= cnt_nx;
      end
   end

   // Stage p0: capture request fields at the handshake edge
   always_ff @(posedge clk) begin
      if (bus.req_valid && bus.req_ready) begin
         we_p0    <= bus.req_we;
         size_p0  <= bus.req_size;
         uns_p0   <= bus.req_unsigned;
         addr_p0  <= bus.req_addr;
         wdata_p0 <= bus.req_wdata;
      end
   end

   // With zero latency the memory access happens on the accept edge itself,
   // so the live bus fields feed the datapath while idle.
   assign sel_live  = (state_p0 == IDLE);
   assign cur_we    = sel_live ? bus.req_we       : we_p0;
   assign cur_size  = sel_live ? bus.req_size     : size_p0;
   assign cur_uns   = sel_live ? bus.req_unsigned : uns_p0;
   assign cur_addr  = sel_live ? bus.req_addr     : addr_p0;
   assign cur_wdata = sel_live ? bus.req_wdata    : wdata_p0;

   assign idx       = cur_addr[AW+1:2];
   assign rword     = mem[idx];
   assign range_err = (cur_addr[31:2] >= 30'(DEPTH));
   assign err       = misalign || range_err;

   dmem_lane_fmt u_fmt (
      .size        (cur_size),
      .is_unsigned (cur_uns),
      .addr_lo     (cur_addr[1:0]),
      .wdata       (cur_wdata),
      .rword       (rword),
      .be          (be),
      .wlane       (wlane),
      .rext        (rext),
      .misalign    (misalign)
   );

   always_ff @(posedge clk) begin
      if (enter_resp && cur_we && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   // Stage p1: registered response, data zeroed outside response cycles
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= enter_resp;
   end

   always_ff @(posedge clk) begin
      err_p1   <= enter_resp && err;
      rdata_p1 <= (enter_resp && !cur_we && !err) ? rext : 32'h0;
   end

   assign bus.rsp_valid = vld_p1 && !reset;
   assign bus.rsp_rdata = bus.rsp_valid ? rdata_p1 : 32'h0;
   assign bus.rsp_err   = bus.rsp_valid && err_p1;

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: a zero-latency and a three-cycle-latency instance driven from a
// shared vector table, with a response scoreboard plus handshake/reset corner sequences.
module tb_dmem_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst3;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_bank_if b0 ();
   dmem_bank_if b3 ();

   dmem_bank #(.DEPTH(64), .LATENCY(0)) u0 (.clk(clk), .reset(rst0), .bus(b0.slave));
   dmem_bank #(.DEPTH(64), .LATENCY(3)) u3 (.clk(clk), .reset(rst3), .bus(b3.slave));

   typedef struct {
      string       nm;
      logic [31:0] rd;
      logic        err;
      int          acc;
   } exp_t;

   typedef struct {
      string       nm;
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   exp_t q0[$];
   exp_t q3[$];
   vec_t vt[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic add(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
      vec_t v;
      v.nm = nm; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
      v.exp_rd = er; v.exp_err = ee;
      vt.push_back(v);
   endtask

   task automatic set_fields(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
      b0.req_we = we; b0.req_size = sz; b0.req_unsigned = uns; b0.req_addr = a; b0.req_wdata = wd;
      b3.req_we = we; b3.req_size = sz; b3.req_unsigned = uns; b3.req_addr = a; b3.req_wdata = wd;
   endtask

   task automatic set_valid(input int d, input logic v);
      if (d == 0) b0.req_valid = v;
      else        b3.req_valid = v;
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? b0.req_ready : b3.req_ready;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q3.size();
   endfunction

   task automatic push(input int d, input string nm, input logic [31:0] rd, input logic e);
      exp_t x;
      x.nm = nm; x.rd = rd; x.err = e; x.acc = cyc;
      if (d == 0) q0.push_back(x);
      else        q3.push_back(x);
   endtask

   task automatic wait_empty(input int d, input string nm);
      int n = 0;
      while (qsize(d) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (qsize(d) != 0) begin
         total++;
         bad++;
         $display("FAIL %s: no response on dut%0d within 40 cycles", nm, d);
         if (d == 0) q0.delete();
         else        q3.delete();
      end
   endtask

   task automatic issue(input int d, input vec_t v);
      int n = 0;
      @(negedge clk);
      set_fields(v.we, v.sz, v.uns, v.addr, v.wd);
      set_valid(d, 1'b1);
      while (!rdy(d) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy(d)) begin
         total++;
         bad++;
         $display("FAIL %s: dut%0d never ready, got 0 want 1", v.nm, d);
         set_valid(d, 1'b0);
      end else begin
         push(d, v.nm, v.exp_rd, v.exp_err);
         @(posedge clk);
         #1;
         set_valid(d, 1'b0);
         wait_empty(d, v.nm);
      end
   endtask

   task automatic mon_one(input int d);
      logic        v, e;
      logic [31:0] r;
      int          lat;
      exp_t        x;
      v   = (d == 0) ? b0.rsp_valid : b3.rsp_valid;
      r   = (d == 0) ? b0.rsp_rdata : b3.rsp_rdata;
      e   = (d == 0) ? b0.rsp_err   : b3.rsp_err;
      lat = (d == 0) ? 0 : 3;
      if (v) begin
         if (qsize(d) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 want 0 (cycle %0d)", d, cyc);
         end else begin
            x = (d == 0) ? q0.pop_front() : q3.pop_front();
            chk({x.nm, "_rdata"}, r, x.rd);
            chk({x.nm, "_err"}, 32'(e), 32'(x.err));
            chk({x.nm, "_latency"}, cyc, x.acc + 1 + lat);
         end
      end else begin
         chk("idle_rdata_zero", r, 32'h0);
         chk("idle_err_zero", 32'(e), 32'h0);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         mon_one(0);
         mon_one(3);
      end
   endtask

   initial begin
      int a;
      vec_t v;
      rst0 = 1'b1;
      rst3 = 1'b1;
      b0.req_valid = 1'b0;
      b3.req_valid = 1'b0;
      set_fields(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      fork
         monitor();
      join_none

      // vectors: name, we, size, unsigned, addr, wdata, expected rdata, expected err
      add("sw_10",      1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0);
      add("lw_10",      0, 2'b10, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
      add("sb_11",      1, 2'b00, 0, 32'h11,       32'h00000080, 32'h0,        0);
      add("lw_10_b",    0, 2'b10, 1, 32'h10,       32'h0,        32'hDEAD80EF, 0);
      add("lb_11",      0, 2'b00, 0, 32'h11,       32'h0,        32'hFFFFFF80, 0);
      add("lbu_11",     0, 2'b00, 1, 32'h11,       32'h0,        32'h00000080, 0);
      add("lhu_12",     0, 2'b01, 1, 32'h12,       32'h0,        32'h0000DEAD, 0);
      add("lh_12",      0, 2'b01, 0, 32'h12,       32'h0,        32'hFFFFDEAD, 0);
      add("lw_12_mis",  0, 2'b10, 0, 32'h12,       32'h0,        32'h0,        1);
      add("sh_13_mis",  1, 2'b01, 0, 32'h13,       32'h00001111, 32'h0,        1);
      add("ld_sz11",    0, 2'b11, 0, 32'h10,       32'h0,        32'h0,        1);
      add("st_sz11",    1, 2'b11, 0, 32'h10,       32'h0,        32'h0,        1);
      add("lw_range",   0, 2'b10, 0, 32'h100,      32'h0,        32'h0,        1);
      add("lw_hiaddr",  0, 2'b10, 0, 32'h80000010, 32'h0,        32'h0,        1);
      add("sw_hiaddr",  1, 2'b10, 0, 32'h80000010, 32'h55555555, 32'h0,        1);
      add("lw_10_keep", 0, 2'b10, 0, 32'h10,       32'h0,        32'hDEAD80EF, 0);
      add("sw_14",      1, 2'b10, 0, 32'h14,       32'h00000000, 32'h0,        0);
      add("sh_16",      1, 2'b01, 0, 32'h16,       32'h1234A5C3, 32'h0,        0);
      add("lh_16",      0, 2'b01, 0, 32'h16,       32'h0,        32'hFFFFA5C3, 0);
      add("lbu_17",     0, 2'b00, 1, 32'h17,       32'h0,        32'h000000A5, 0);
      add("lb_17",      0, 2'b00, 0, 32'h17,       32'h0,        32'hFFFFFFA5, 0);
      add("sb_14",      1, 2'b00, 0, 32'h14,       32'hFFFFFF7F, 32'h0,        0);
      add("lw_14",      0, 2'b10, 1, 32'h14,       32'h0,        32'hA5C3007F, 0);
      add("lh_14",      0, 2'b01, 0, 32'h14,       32'h0,        32'h0000007F, 0);
      add("lb_15",      0, 2'b00, 0, 32'h15,       32'h0,        32'h00000000, 0);

      repeat (3) @(negedge clk);
      chk("rst_ready0", 32'(b0.req_ready), 32'h0);
      chk("rst_ready3", 32'(b3.req_ready), 32'h0);
      chk("rst_valid0", 32'(b0.rsp_valid), 32'h0);
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      chk("post_rst_ready0", 32'(b0.req_ready), 32'h1);
      chk("post_rst_ready3", 32'(b3.req_ready), 32'h1);

      foreach (vt[i]) issue(0, vt[i]);
      foreach (vt[i]) issue(3, vt[i]);

      // Latency-3 handshake: a request held during the busy window is taken once idle.
      add("sw_20", 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
      issue(3, vt[vt.size()-1]);
      @(negedge clk);
      set_fields(1'b1, 2'b10, 1'b0, 32'h24, 32'h55AA55AA);
      set_valid(3, 1'b1);
      chk("l3_ready_pre", 32'(b3.req_ready), 32'h1);
      a = cyc;
      push(3, "l3_sw_24", 32'h0, 1'b0);
      @(negedge clk);
      set_fields(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("l3_busy_ready_c%0d", k), 32'(b3.req_ready), 32'h0);
      end
      @(negedge clk);
      chk("l3_ready_back", 32'(b3.req_ready), 32'h1);
      chk("l3_ready_back_cycle", cyc, a + 5);
      push(3, "l3_lw_24", 32'h55AA55AA, 1'b0);
      @(posedge clk);
      #1;
      set_valid(3, 1'b0);
      wait_empty(3, "l3_lw_24");

      // Reset two cycles after accept aborts the store; the old word survives.
      @(negedge clk);
      set_fields(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
      set_valid(3, 1'b1);
      chk("abort_ready", 32'(b3.req_ready), 32'h1);
      @(posedge clk);
      #1;
      set_valid(3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst3 = 1'b1;
      chk("abort_rst_ready", 32'(b3.req_ready), 32'h0);
      @(negedge clk);
      chk("abort_rst_valid", 32'(b3.rsp_valid), 32'h0);
      @(posedge clk);
      #1;
      rst3 = 1'b0;
      @(negedge clk);
      chk("abort_post_ready", 32'(b3.req_ready), 32'h1);
      repeat (6) @(negedge clk);
      v.nm = "lw_20_after_abort"; v.we = 1'b0; v.sz = 2'b10; v.uns = 1'b0;
      v.addr = 32'h20; v.wd = 32'h0; v.exp_rd = 32'hCAFEF00D; v.exp_err = 1'b0;
      issue(3, v);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_bank.md
DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 0, wait cycles inserted before each response (0..7).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned, input, 1, load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr, input, 32, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, request faulted; valid only with rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request (handshake) in a cycle where req_valid and req_ready are both 1; all request fields are captured at that edge.
REQ-017 On accept, SHALL go IDLE->RESP if LATENCY=0, else IDLE->WAIT, loading a down-counter with LATENCY-1.
REQ-018 SHALL stay in WAIT while counter != 0, decrementing by 1 per cycle; at 0 SHALL go WAIT->RESP.
REQ-019 In RESP, SHALL assert rsp_valid for exactly one cycle and then return to IDLE; accept at cycle t gives rsp_valid at t+1+LATENCY.
REQ-020 Lane mapping SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1], word index = addr[log2(DEPTH)+1:2].
REQ-021 Stores SHALL write only the addressed byte/half/word lanes, leaving other lanes unchanged; the write commits on the edge entering RESP.
REQ-022 Loads SHALL read the word on the edge entering RESP, extract the lane, and extend to 32 bits per req_unsigned; the word-size load ignores req_unsigned.
REQ-023 SHALL flag rsp_err=1, perform no write, and return rsp_rdata=0 when: half with addr[0]=1; word with addr[1:0]!=0; req_size=11; or addr[31:2] >= DEPTH.
REQ-024 A load following a store to the same word SHALL return the stored data (no stale read).
REQ-025 rsp_rdata and rsp_err SHALL be registered, and SHALL be held 0 in every cycle without rsp_valid.
REQ-026 req_valid while not IDLE SHALL be ignored (no capture); the requester SHALL hold the request until req_ready is 1.

Reset
REQ-027 While reset=1: state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 In the first cycle after reset deasserts, req_ready SHALL be 1.
REQ-029 Reset during WAIT/RESP SHALL abort the request without writing memory and without a response.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package dmem_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W), the FSM state enum, and the lane-extract/merge functions.
REQ-032 Sub-module dmem_lane_fmt (combinational: store byte-enable/merge, load extract/extend) is natural and SHALL be used by dmem_bank.
REQ-033 Storage SHALL be a single DEPTH x 32 array with per-byte write enables, synthesizable as RAM.

Verification
REQ-034 LATENCY=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-035 sb 0x80 @0x11 over 0xDEADBEEF -> word=0xDEAD80EF; lb @0x11 -> 0xFFFFFF80; lbu @0x11 -> 0x00000080; lhu @0x12 -> 0x0000DEAD.
REQ-036 lw @0x12, sh @0x13, size=11, and lw @DEPTH*4 -> each rsp_err=1, rdata=0, memory unchanged.
REQ-037 LATENCY=3: accept at cycle 10 -> req_ready=0 in cycles 11-14, rsp_valid at 14 only, req_ready=1 at 15; a req_valid held during cycles 11-14 is accepted at 15.
REQ-038 LATENCY=3: sw 0x12345678 @0x20, reset asserted 2 cycles after accept -> no rsp_valid; a later lw @0x20 returns the prior contents.
